// File: rtl/key_table_pkg.sv
// Shared types and pair-layout helpers for the MuxKey key/value table family.
// A pair n is packed as {key, data}, with data in the low bits.
package key_table_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int unsigned pair_len(input int unsigned key_len,
                                            input int unsigned data_len);
      return key_len + data_len;
   endfunction

   function automatic int unsigned pair_data_lsb(input int unsigned n,
                                                 input int unsigned key_len,
                                                 input int unsigned data_len);
      return n * pair_len(key_len, data_len);
   endfunction

   function automatic int unsigned pair_key_lsb(input int unsigned n,
                                                input int unsigned key_len,
                                                input int unsigned data_len);
      return pair_data_lsb(n, key_len, data_len) + data_len;
   endfunction

endpackage

// File: rtl/key_table_encoder_if.sv
// Request/response valid-ready bundle for key_table_encoder.
interface key_table_encoder_if #(
   parameter int KEY_LEN  = 2,
   parameter int DATA_LEN = 2,
   parameter int IDX_LEN  = 2
);
   logic                req_valid;
   logic                req_ready;
   logic [DATA_LEN-1:0] req_data;
   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_hit;
   logic [KEY_LEN-1:0]  rsp_key;
   logic [IDX_LEN-1:0]  rsp_index;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_hit, rsp_key, rsp_index
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_hit, rsp_key, rsp_index
   );
endinterface

// File: rtl/key_table_pair_slice.sv
// Unpacks a flat {key, data} lookup table into separate key and data arrays.
module key_table_pair_slice
   import key_table_pkg::*;
#(
   parameter int NR_KEY   = 4,
   parameter int KEY_LEN  = 2,
   parameter int DATA_LEN = 2
) (
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
   output logic [KEY_LEN-1:0]                   key_arr  [NR_KEY],
   output logic [DATA_LEN-1:0]                  data_arr [NR_KEY]
);

   for (genvar n = 0; n < NR_KEY; n++) begin : g_pair
      assign key_arr[n]  = lut[pair_key_lsb(n, KEY_LEN, DATA_LEN)  +: KEY_LEN];
      assign data_arr[n] = lut[pair_data_lsb(n, KEY_LEN, DATA_LEN) +: DATA_LEN];
   end

endmodule

// File: rtl/key_table_encoder.sv
// Reverse key lookup: scans a snapshot of the table one entry per cycle.
// Optional KEY_TABLE_ENCODER_DEFAULT_EN adds a default_key reported on a miss.
module key_table_encoder
   import key_table_pkg::*;
#(
   parameter int NR_KEY   = 4,
   parameter int KEY_LEN  = 2,
   parameter int DATA_LEN = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
`ifdef KEY_TABLE_ENCODER_DEFAULT_EN
   input  logic [KEY_LEN-1:0]                   default_key,
`endif
   key_table_encoder_if.slave                   bus
);

   localparam int IDX_LEN = $clog2(NR_KEY);
   localparam int LUT_W   = NR_KEY * pair_len(KEY_LEN, DATA_LEN);
   localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(NR_KEY - 1);

   state_e               state_q, state_d;
   logic [IDX_LEN-1:0]   cnt_q,   cnt_d;
   logic [LUT_W-1:0]     lut_q,   lut_d;
   logic [DATA_LEN-1:0]  data_q,  data_d;
   logic                 hit_q,   hit_d;
   logic [KEY_LEN-1:0]   key_q,   key_d;
   logic [IDX_LEN-1:0]   idx_q,   idx_d;
   logic [KEY_LEN-1:0]   miss_key;

   logic [KEY_LEN-1:0]   key_arr  [NR_KEY];
   logic [DATA_LEN-1:0]  data_arr [NR_KEY];

`ifdef KEY_TABLE_ENCODER_DEFAULT_EN
   logic [KEY_LEN-1:0]   dflt_q, dflt_d;
   assign miss_key = dflt_q;
`else
   assign miss_key = '0;
`endif

   // Comparison runs against the snapshot so later lut changes cannot leak in.
   key_table_pair_slice #(
      .NR_KEY   (NR_KEY),
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN)
   ) u_slice (
      .lut      (lut_q),
      .key_arr  (key_arr),
      .data_arr (data_arr)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      lut_d   = lut_q;
      data_d  = data_q;
      hit_d   = hit_q;
      key_d   = key_q;
      idx_d   = idx_q;
`ifdef KEY_TABLE_ENCODER_DEFAULT_EN
      dflt_d  = dflt_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               lut_d   = lut;
               data_d  = bus.req_data;
`ifdef KEY_TABLE_ENCODER_DEFAULT_EN
               dflt_d  = default_key;
`endif
               cnt_d   = '0;
               state_d = SCAN;
            end
         end

         SCAN: begin
            if (data_arr[cnt_q] == data_q) begin
               hit_d   = 1'b1;
               key_d   = key_arr[cnt_q];
               idx_d   = cnt_q;
               state_d = DONE;
            end else if (cnt_q == LAST_IDX) begin
               hit_d   = 1'b0;
               key_d   = miss_key;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + IDX_LEN'(1);
            end
         end

         DONE: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: the snapshot is a plain register, not a RAM, so it is reset with everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lut_q   <= '0;
         data_q  <= '0;
         hit_q   <= 1'b0;
         key_q   <= '0;
         idx_q   <= '0;
`ifdef KEY_TABLE_ENCODER_DEFAULT_EN
         dflt_q  <= '0;
`endif
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lut_q   <= lut_d;
         data_q  <= data_d;
         hit_q   <= hit_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
`ifdef KEY_TABLE_ENCODER_DEFAULT_EN
         dflt_q  <= dflt_d;
`endif
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == DONE);
   assign bus.rsp_hit   = hit_q;
   assign bus.rsp_key   = key_q;
   assign bus.rsp_index = idx_q;

endmodule

// File: tb/tb_key_table_encoder.sv
// Scoreboard bench for key_table_encoder: driver pushes model results, monitor pops on response.
module tb_key_table_encoder;

   localparam int NR_KEY   = 4;
   localparam int KEY_LEN  = 2;
   localparam int DATA_LEN = 2;
   localparam int IDX_LEN  = 2;
   localparam int PAIR     = KEY_LEN + DATA_LEN;
   localparam int LUT_W    = NR_KEY * PAIR;

   typedef struct {
      bit                 hit;
      logic [KEY_LEN-1:0] key;
      logic [IDX_LEN-1:0] idx;
      int                 t_acc;
      int                 lat;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic [LUT_W-1:0]   lut;
   logic [KEY_LEN-1:0] default_key;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   next_bp = 0;
   int   wait_cnt = 0;
   exp_t exp_q[$];

   bit                 have_first = 0;
   bit                 pend_bubble = 0;
   logic               f_hit;
   logic [KEY_LEN-1:0] f_key;
   logic [IDX_LEN-1:0] f_idx;

   key_table_encoder_if #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .IDX_LEN(IDX_LEN)) bus ();

   key_table_encoder #(
      .NR_KEY   (NR_KEY),
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lut         (lut),
`ifdef KEY_TABLE_ENCODER_DEFAULT_EN
      .default_key (default_key),
`endif
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: first table entry (lowest index) whose data equals the request.
   function automatic exp_t model(input logic [LUT_W-1:0] tbl, input logic [DATA_LEN-1:0] d,
                                  input logic [KEY_LEN-1:0] dk, input int t);
      exp_t e;
      e.hit = 0; e.key = '0; e.idx = '0; e.t_acc = t; e.lat = NR_KEY;
`ifdef KEY_TABLE_ENCODER_DEFAULT_EN
      e.key = dk;
`endif
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (tbl[i*PAIR +: DATA_LEN] == d) begin
            e.hit = 1;
            e.key = tbl[i*PAIR + DATA_LEN +: KEY_LEN];
            e.idx = IDX_LEN'(i);
            e.lat = 1 + i;
         end
      end
      return e;
   endfunction

   // Consumer backpressure: rsp_ready held low for next_bp cycles of each response.
   initial bus.rsp_ready = 1'b0;
   always @(posedge clk) begin
      #2;
      if (bus.rsp_valid) begin
         if (wait_cnt > 0) begin
            bus.rsp_ready = 1'b0;
            wait_cnt--;
         end else begin
            bus.rsp_ready = 1'b1;
         end
      end else begin
         bus.rsp_ready = 1'b0;
         wait_cnt      = next_bp;
      end
   end

   // Monitor: compares each presented response against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         have_first  = 0;
         pend_bubble = 0;
      end else begin
         if (pend_bubble) begin
            check("bubble_req_ready", 32'(bus.req_ready), 32'd1);
            pend_bubble = 0;
         end
         if (bus.rsp_valid) begin
            check("busy_req_ready", 32'(bus.req_ready), 32'd0);
            if (!have_first) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  check("rsp_latency", 32'(cyc), 32'(exp_q[0].t_acc + exp_q[0].lat));
                  check("rsp_hit",     32'(bus.rsp_hit),   32'(exp_q[0].hit));
                  check("rsp_key",     32'(bus.rsp_key),   32'(exp_q[0].key));
                  check("rsp_index",   32'(bus.rsp_index), 32'(exp_q[0].idx));
               end
               f_hit = bus.rsp_hit; f_key = bus.rsp_key; f_idx = bus.rsp_index;
               have_first = 1;
            end else begin
               check("rsp_stable", {27'd0, bus.rsp_hit, bus.rsp_key, bus.rsp_index},
                     {27'd0, f_hit, f_key, f_idx});
            end
            if (bus.rsp_ready) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               have_first  = 0;
               pend_bubble = 1;
            end
         end
      end
   end

   task automatic send(input logic [LUT_W-1:0] tbl, input logic [DATA_LEN-1:0] d,
                       input logic [KEY_LEN-1:0] dk, input bit scramble);
      int n = 0;
      @(negedge clk);
      lut = tbl; bus.req_data = d; default_key = dk; bus.req_valid = 1'b1;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         check("req_accept_timeout", 32'd0, 32'd1);
         bus.req_valid = 1'b0;
      end else begin
         exp_q.push_back(model(tbl, d, dk, cyc + 1));
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (scramble) lut = LUT_W'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("rsp_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; lut = '0; default_key = '0;
      bus.req_valid = 1'b0; bus.req_data = '0;
      repeat (2) @(negedge clk);
      check("reset_req_ready", 32'(bus.req_ready), 32'd1);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_rsp_fields", {27'd0, bus.rsp_hit, bus.rsp_key, bus.rsp_index}, 32'd0);
      rst_n = 1'b1;

      // Table {k0,d3},{k1,d2},{k2,d1},{k3,d0}; duplicate-data and all-miss variants.
      send(16'hC963, 2'd1, 2'd0, 1'b0);
      send(16'hE963, 2'd2, 2'd0, 1'b0);
      send(16'hFB73, 2'd0, 2'd3, 1'b0);
      wait_idle();

      // Long backpressure while lut changes right after acceptance.
      next_bp = 5;
      send(16'hC963, 2'd3, 2'd1, 1'b1);
      wait_idle();
      next_bp = 0;

      // Reset during the second scan cycle: no response may follow.
      lut = 16'hC963; bus.req_data = 2'd0; bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midscan_req_ready", 32'(bus.req_ready), 32'd1);
      check("midscan_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midscan_rsp_fields", {27'd0, bus.rsp_hit, bus.rsp_key, bus.rsp_index}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(16'hC963, 2'd2, 2'd0, 1'b0);
      wait_idle();

      for (int i = 0; i < 150; i++) begin
         next_bp = $urandom_range(0, 3);
         send(LUT_W'($urandom), DATA_LEN'($urandom), KEY_LEN'($urandom), 1'($urandom_range(0, 1)));
      end
      wait_idle();
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
